spi_frame_fsm: RTL and testbench



---
 rtl/spi_frame_fsm.sv | 161 ++++++++++++++++
 tb/tb_spi_frame_fsm.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_fsm.sv
// SPI slave frame controller: decodes address, R/W and data from conditioned SCLK/MOSI,
// drives a synchronous memory port and shifts read data out on MISO.
module spi_frame_fsm #(
    parameter int unsigned ADDR_WIDTH = 7,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cs_cond,
    input  logic                  sclk_rise,
    input  logic                  sclk_fall,
    input  logic                  mosi_cond,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    output logic                  miso,
    output logic                  miso_oe
);

    localparam int unsigned HDR_BITS = ADDR_WIDTH + 1;
    localparam int unsigned RX_W     = (HDR_BITS > DATA_WIDTH) ? HDR_BITS : DATA_WIDTH;
    localparam int unsigned CNT_W    = $clog2(RX_W + 1);
    localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(ADDR_WIDTH);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_ADDR,
        ST_READ_LOAD,
        ST_READ_SHIFT,
        ST_WRITE_SHIFT,
        ST_WRITE_COMMIT,
        ST_DONE
    } state_e;

    state_e                state_q, state_d;
    logic [RX_W-1:0]       rx_q, rx_d, rx_shift;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] tx_q, tx_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  mem_we_q, mem_we_d;
    logic                  miso_q, miso_d;
    logic                  miso_oe_q, miso_oe_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            rx_q        <= '0;
            cnt_q       <= '0;
            tx_q        <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            miso_q      <= 1'b0;
            miso_oe_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rx_q        <= rx_d;
            cnt_q       <= cnt_d;
            tx_q        <= tx_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            miso_q      <= miso_d;
            miso_oe_q   <= miso_oe_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rx_d        = rx_q;
        cnt_d       = cnt_q;
        tx_d        = tx_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        miso_d      = miso_q;
        miso_oe_d   = miso_oe_q;
        rx_shift    = {rx_q[RX_W-2:0], mosi_cond};

        // Chip-select release aborts the frame ahead of any SCLK activity
        if (state_q != ST_IDLE && cs_cond) begin
            state_d   = ST_IDLE;
            miso_oe_d = 1'b0;
            cnt_d     = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!cs_cond) begin
                        state_d = ST_GET_ADDR;
                        cnt_d   = '0;
                        rx_d    = '0;
                    end
                end
                ST_GET_ADDR: begin
                    if (sclk_rise) begin
                        rx_d = rx_shift;
                        if (cnt_q == HDR_LAST) begin
                            mem_addr_d = rx_shift[ADDR_WIDTH:1];
                            cnt_d      = '0;
                            state_d    = rx_shift[0] ? ST_READ_LOAD : ST_WRITE_SHIFT;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_READ_LOAD: begin
                    tx_d      = mem_rdata;
                    miso_oe_d = 1'b1;
                    state_d   = ST_READ_SHIFT;
                end
                ST_READ_SHIFT: begin
                    // A rise coinciding with a fall wins; the fall is dropped
                    if (sclk_rise) begin
                        if (cnt_q == DATA_LAST) begin
                            cnt_d     = '0;
                            miso_oe_d = 1'b0;
                            state_d   = ST_DONE;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else if (sclk_fall) begin
                        miso_d = tx_q[DATA_WIDTH-1];
                        tx_d   = {tx_q[DATA_WIDTH-2:0], 1'b0};
                    end
                end
                ST_WRITE_SHIFT: begin
                    if (sclk_rise) begin
                        rx_d = rx_shift;
                        if (cnt_q == DATA_LAST) begin
                            mem_wdata_d = rx_shift[DATA_WIDTH-1:0];
                            mem_we_d    = 1'b1;
                            cnt_d       = '0;
                            state_d     = ST_WRITE_COMMIT;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_WRITE_COMMIT: begin
                    state_d = ST_DONE;
                end
                ST_DONE: begin
                    miso_oe_d = 1'b0;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign miso      = miso_q;
    assign miso_oe   = miso_oe_q;

endmodule

// File: tb/tb_spi_frame_fsm.sv
// Bench for spi_frame_fsm: drives SPI frames as a master would and checks the memory
// port and MISO stream against a frame-level model of memory contents.
module tb_spi_frame_fsm;

    localparam int unsigned AW    = 7;
    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 2 ** AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          cs_cond;
    logic          sclk_rise;
    logic          sclk_fall;
    logic          mosi_cond;
    logic [DW-1:0] mem_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic          miso;
    logic          miso_oe;

    int checks = 0;
    int errors = 0;
    int we_cnt = 0;
    logic [AW-1:0] we_addr;
    logic [DW-1:0] we_data;

    // Environment memory, preloaded through a load port so only one process writes it
    logic [DW-1:0] mem [DEPTH];
    logic          load_en;
    logic [AW-1:0] load_idx;
    logic [DW-1:0] load_val;

    // Model state: expected memory image and expected held port values
    logic [DW-1:0] ref_mem [DEPTH];
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata;

    always #5 clk = ~clk;

    spi_frame_fsm #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .cs_cond   (cs_cond),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .mosi_cond (mosi_cond),
        .mem_rdata (mem_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .miso      (miso),
        .miso_oe   (miso_oe)
    );

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (load_en) mem[load_idx] <= load_val;
        else if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    always @(negedge clk) begin
        if (mem_we) begin
            we_cnt  = we_cnt + 1;
            we_addr = mem_addr;
            we_data = mem_wdata;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rise_pulse(input logic b);
        mosi_cond = b;
        sclk_rise = 1'b1;
        tick();
        sclk_rise = 1'b0;
    endtask

    task automatic fall_with_gaps();
        repeat ($urandom_range(1, 3)) tick();
        sclk_fall = 1'b1;
        tick();
        sclk_fall = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
    endtask

    // mode 0: full frame; 1: CS raised after nbits; 2: reset after nbits;
    // 3: CS raised on the same clock as rise number nbits
    task automatic frame(input logic [AW-1:0] a, input logic rw, input logic [DW-1:0] d,
                         input int mode, input int nbits, input int extra);
        logic [AW+DW:0] fr;
        logic [DW-1:0]  rd;
        int             we0;
        logic           commit;
        fr     = {a, rw, d};
        rd     = ref_mem[a];
        we0    = we_cnt;
        commit = 1'b0;
        cs_cond = 1'b0;
        repeat ($urandom_range(1, 2)) tick();
        for (int i = 0; i <= int'(AW + DW); i++) begin
            if (mode == 3 && i == nbits) begin
                cs_cond = 1'b1;
                rise_pulse(fr[AW+DW-i]);
                break;
            end
            if ((mode == 1 || mode == 2) && i == nbits) break;
            if (rw && i > int'(AW)) begin
                chk("miso_bit", 32'(miso), 32'(rd[DW-1-(i-AW-1)]));
                chk("miso_oe_on", 32'(miso_oe), 32'd1);
            end
            rise_pulse(fr[AW+DW-i]);
            if (i == int'(AW)) exp_addr = a;
            if (i == int'(AW + DW)) begin
                if (rw) begin
                    chk("miso_oe_off", 32'(miso_oe), 32'd0);
                end else begin
                    chk("we_latency", 32'(mem_we), 32'd1);
                    commit    = 1'b1;
                    exp_wdata = d;
                    ref_mem[a] = d;
                end
            end
            fall_with_gaps();
        end
        for (int k = 0; k < extra; k++) begin
            rise_pulse(1'($urandom));
            fall_with_gaps();
        end
        if (extra > 0) begin
            chk("done_oe", 32'(miso_oe), 32'd0);
            chk("done_we", 32'(mem_we), 32'd0);
        end
        if (mode == 2) begin
            reset = 1'b1;
            tick();
            chk("rst_addr", 32'(mem_addr), 32'd0);
            chk("rst_wdata", 32'(mem_wdata), 32'd0);
            chk("rst_we", 32'(mem_we), 32'd0);
            chk("rst_miso", 32'(miso), 32'd0);
            chk("rst_oe", 32'(miso_oe), 32'd0);
            exp_addr  = '0;
            exp_wdata = '0;
            reset     = 1'b0;
        end
        cs_cond = 1'b1;
        tick();
        tick();
        chk("we_count", 32'(we_cnt - we0), commit ? 32'd1 : 32'd0);
        if (commit) begin
            chk("we_addr", 32'(we_addr), 32'(a));
            chk("we_data", 32'(we_data), 32'(d));
        end
        chk("hold_addr", 32'(mem_addr), 32'(exp_addr));
        chk("hold_wdata", 32'(mem_wdata), 32'(exp_wdata));
        chk("idle_oe", 32'(miso_oe), 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        cs_cond   = 1'b1;
        sclk_rise = 1'b0;
        sclk_fall = 1'b0;
        mosi_cond = 1'b0;
        load_en   = 1'b1;
        load_idx  = '0;
        load_val  = '0;
        exp_addr  = '0;
        exp_wdata = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            load_idx   = AW'(i);
            load_val   = DW'($urandom);
            ref_mem[i] = load_val;
            tick();
        end
        load_en = 1'b0;

        chk("reset_addr", 32'(mem_addr), 32'd0);
        chk("reset_wdata", 32'(mem_wdata), 32'd0);
        chk("reset_we", 32'(mem_we), 32'd0);
        chk("reset_miso", 32'(miso), 32'd0);
        chk("reset_oe", 32'(miso_oe), 32'd0);
        reset = 1'b0;
        tick();

        frame(7'h2A, 1'b0, 8'hC5, 0, 0, 0);
        frame(7'h2A, 1'b1, 8'h00, 0, 0, 0);
        frame(7'h11, 1'b0, 8'h5A, 1, 12, 0);
        frame(7'h11, 1'b0, 8'h3C, 0, 0, 0);
        frame(7'h11, 1'b1, 8'h00, 0, 0, 0);
        frame(7'h2A, 1'b1, 8'h00, 2, 10, 0);
        frame(7'h05, 1'b0, 8'h96, 0, 0, 0);
        frame(7'h05, 1'b1, 8'h00, 0, 0, 0);
        frame(7'h33, 1'b0, 8'hA7, 0, 0, 5);
        frame(7'h0F, 1'b0, 8'h12, 3, 3, 0);
        frame(7'h0F, 1'b1, 8'h00, 0, 0, 0);
        for (int n = 0; n < 24; n++) begin
            frame(AW'($urandom), 1'($urandom), DW'($urandom), 0, 0, int'($urandom_range(0, 2)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
